lisp_eval_engine: RTL and testbench

// - Parametrised evaluator for cons-cell expressions in heap memory. Handles numbers and

---
 rtl/lisp_eval_engine_pkg.sv | 56 +++++
 rtl/lisp_eval_engine_stack.sv | 58 +++++
 rtl/lisp_eval_engine.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_lisp_eval_engine.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lisp_eval_engine_pkg.sv
// Shared definitions for the cons-cell expression evaluator.
//   - Cell type tags as delivered on mem_header (GC bit already stripped).
//   - Primitive opcodes stored in the car of a TYPE_PRIMITIVE cell.
//   - Error codes reported on error_code.
//   - frame_t: one pending application (continuation) held on the eval stack.
//     Fields are sized for the 16-bit car/cdr of the heap. The evaluator's
//     ADDR_W and DATA_W are therefore at most 16 and are zero-extended into
//     these fields.
package lisp_defs;

  localparam logic [14:0] TYPE_NUMBER    = 15'd1;
  localparam logic [14:0] TYPE_CONS      = 15'd2;
  localparam logic [14:0] TYPE_PRIMITIVE = 15'd3;

  localparam logic [15:0] PRIMOP_ADD = 16'd0;
  localparam logic [15:0] PRIMOP_SUB = 16'd1;
  localparam logic [15:0] PRIMOP_MUL = 16'd2;

  // Heap address 0 is the empty list.
  localparam int NIL = 0;

  localparam logic [3:0] ERR_ILLEGAL   = 4'd0;
  localparam logic [3:0] ERR_EVAL_TYPE = 4'd2;
  localparam logic [3:0] ERR_APPLY     = 4'd3;
  localparam logic [3:0] ERR_OVERFLOW  = 4'd4;
  localparam logic [3:0] ERR_ARITY     = 4'd5;

  localparam int FRAME_FIELD_W = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  typedef struct packed {
    op_e                      op;
    logic [FRAME_FIELD_W-1:0] acc;
    logic [FRAME_FIELD_W-1:0] args;
    logic                     first;
  } frame_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_EVAL,
    S_FETCH_OP,
    S_APPLY,
    S_FETCH_ARG,
    S_ARG,
    S_COMBINE,
    S_DONE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/lisp_eval_engine_stack.sv
// eval_stack: LIFO of continuation frames for the evaluator.
// Ports:
//   clk, rst  clock and synchronous active-high reset (empties the stack)
//   push      write din on top (ignored when full)
//   pop       discard top entry (ignored when empty)
//   din       frame to push
//   dout      current top-of-stack frame (valid while !empty)
//   empty     no frames held
//   full      DEPTH frames held
// push and pop in the same cycle is not supported.
module eval_stack
  import lisp_defs::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  frame_t din,
  output frame_t dout,
  output logic   empty,
  output logic   full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  frame_t           mem_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;

  assign wr_idx = PTR_W'(count_q);
  assign rd_idx = PTR_W'(count_q - 1'b1);
  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign dout   = mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (push && !full) begin
      count_q <= count_q + 1'b1;
    end else if (pop && !empty) begin
      count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx] <= din;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && pop));

endmodule

// File: rtl/lisp_eval_engine.sv
// lisp_eval_engine: evaluates a cons-cell expression held in heap memory.
// An expression is a NUMBER cell or an application (op arg ...) whose op is a
// PRIMITIVE cell (ADD/SUB/MUL). Arguments may themselves be applications; the
// enclosing application is parked on eval_stack while a nested one runs.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        pulse in IDLE: evaluate the expression at expr_addr
//   expr_addr    root expression address
//   mem_req      read request, held until mem_ready
//   mem_addr     read address, stable while mem_req
//   mem_ready    pulse: mem_header/mem_car/mem_cdr valid this cycle
//   mem_header   cell type tag
//   mem_car      car field
//   mem_cdr      cdr field
//   busy         evaluation in progress
//   done         one-cycle pulse, result valid
//   result       last result, held until overwritten
//   error        sticky error flag, cleared by the next accepted start
//   error_code   cause of the last error
module lisp_eval_engine
  import lisp_defs::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] expr_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [14:0]       mem_header,
  input  logic [15:0]       mem_car,
  input  logic [15:0]       mem_cdr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              error,
  output logic [3:0]        error_code
);

  localparam logic [ADDR_W-1:0] NIL_ADDR = ADDR_W'(NIL);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [14:0]       hdr_q, hdr_d;
  logic [15:0]       car_q, car_d;
  logic [15:0]       cdr_q, cdr_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0] args_q, args_d;
  logic              first_q, first_d;
  logic              arg_mode_q, arg_mode_d;   // fetched cell is an argument, not the root
  logic [DATA_W-1:0] v_q, v_d;                 // value of the application just completed
  logic [DATA_W-1:0] result_q, result_d;
  logic              error_q, error_d;
  logic [3:0]        error_code_q, error_code_d;

  logic              stk_push, stk_pop, stk_empty, stk_full, stk_rst;
  frame_t            stk_din, stk_dout;

  // Argument-application datapath, shared by direct numeric arguments and
  // by values returned from a nested application.
  logic              do_apply;
  logic [DATA_W-1:0] ap_x, ap_acc, ap_acc_new;
  op_e               ap_op;
  logic              ap_first;
  logic [ADDR_W-1:0] ap_args;

  logic              err_go;
  logic [3:0]        err_code;

  logic [ADDR_W-1:0] car_addr, cdr_addr;
  logic [DATA_W-1:0] car_val;

  assign car_addr = car_q[ADDR_W-1:0];
  assign cdr_addr = cdr_q[ADDR_W-1:0];
  assign car_val  = car_q[DATA_W-1:0];

  function automatic logic [DATA_W-1:0] alu(input op_e op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      default: return a;
    endcase
  endfunction

  // A previous run may have ended in an error with frames still stacked;
  // an accepted start discards them.
  assign stk_rst = rst | ((state_q == S_IDLE) & start);

  assign stk_din = '{op: op_q, acc: FRAME_FIELD_W'(acc_q),
                     args: FRAME_FIELD_W'(args_q), first: first_q};

  eval_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk  (clk),
    .rst  (stk_rst),
    .push (stk_push),
    .pop  (stk_pop),
    .din  (stk_din),
    .dout (stk_dout),
    .empty(stk_empty),
    .full (stk_full)
  );

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    hdr_d        = hdr_q;
    car_d        = car_q;
    cdr_d        = cdr_q;
    op_d         = op_q;
    acc_d        = acc_q;
    args_d       = args_q;
    first_d      = first_q;
    arg_mode_d   = arg_mode_q;
    v_d          = v_q;
    result_d     = result_q;
    error_d      = error_q;
    error_code_d = error_code_q;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
    do_apply     = 1'b0;
    err_go       = 1'b0;
    err_code     = ERR_ILLEGAL;
    ap_x         = car_val;
    ap_op        = op_q;
    ap_acc       = acc_q;
    ap_first     = first_q;
    ap_args      = args_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d      = 1'b0;
          error_code_d = ERR_ILLEGAL;
          arg_mode_d   = 1'b0;
          mem_addr_d   = expr_addr;
          mem_req_d    = 1'b1;
          state_d      = S_FETCH;
        end
      end

      S_FETCH, S_FETCH_OP, S_FETCH_ARG: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          hdr_d     = mem_header;
          car_d     = mem_car;
          cdr_d     = mem_cdr;
          if (state_q == S_FETCH) begin
            state_d = S_EVAL;
          end else if (state_q == S_FETCH_OP) begin
            state_d = S_APPLY;
          end else begin
            state_d = S_ARG;
          end
        end
      end

      S_EVAL: begin
        if (hdr_q == TYPE_NUMBER) begin
          if (arg_mode_q) begin
            do_apply = 1'b1;
          end else begin
            v_d     = car_val;
            state_d = S_COMBINE;
          end
        end else if (hdr_q == TYPE_CONS) begin
          if (arg_mode_q && stk_full) begin
            err_go   = 1'b1;
            err_code = ERR_OVERFLOW;
          end else begin
            // Park the enclosing application before starting the nested one.
            stk_push   = arg_mode_q;
            args_d     = cdr_addr;
            first_d    = 1'b1;
            mem_addr_d = car_addr;
            mem_req_d  = 1'b1;
            state_d    = S_FETCH_OP;
          end
        end else begin
          err_go   = 1'b1;
          err_code = ERR_EVAL_TYPE;
        end
      end

      S_APPLY: begin
        if (hdr_q != TYPE_PRIMITIVE ||
            !(car_q == PRIMOP_ADD || car_q == PRIMOP_SUB || car_q == PRIMOP_MUL)) begin
          err_go   = 1'b1;
          err_code = ERR_APPLY;
        end else begin
          op_d = op_e'(car_q[1:0]);
          if (args_q == NIL_ADDR) begin
            if (car_q == PRIMOP_SUB) begin
              err_go   = 1'b1;
              err_code = ERR_ARITY;
            end else begin
              v_d     = (car_q == PRIMOP_MUL) ? DATA_W'(1) : '0;
              state_d = S_COMBINE;
            end
          end else begin
            mem_addr_d = args_q;
            mem_req_d  = 1'b1;
            state_d    = S_FETCH_ARG;
          end
        end
      end

      S_ARG: begin
        if (hdr_q == TYPE_CONS) begin
          args_d     = cdr_addr;
          arg_mode_d = 1'b1;
          mem_addr_d = car_addr;
          mem_req_d  = 1'b1;
          state_d    = S_FETCH;
        end else begin
          err_go   = 1'b1;
          err_code = ERR_EVAL_TYPE;
        end
      end

      S_COMBINE: begin
        if (stk_empty) begin
          result_d = v_q;
          state_d  = S_DONE;
        end else begin
          // Resume the parked application with v as its next argument.
          stk_pop  = 1'b1;
          do_apply = 1'b1;
          ap_x     = v_q;
          ap_op    = stk_dout.op;
          ap_acc   = stk_dout.acc[DATA_W-1:0];
          ap_first = stk_dout.first;
          ap_args  = stk_dout.args[ADDR_W-1:0];
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;

      default: begin
        err_go   = 1'b1;
        err_code = ERR_ILLEGAL;
      end
    endcase

    ap_acc_new = ap_first ? ap_x : alu(ap_op, ap_acc, ap_x);

    if (do_apply) begin
      acc_d   = ap_acc_new;
      first_d = 1'b0;
      op_d    = ap_op;
      args_d  = ap_args;
      if (ap_args == NIL_ADDR) begin
        v_d     = ap_acc_new;
        state_d = S_COMBINE;
      end else begin
        mem_addr_d = ap_args;
        mem_req_d  = 1'b1;
        state_d    = S_FETCH_ARG;
      end
    end

    if (err_go) begin
      state_d      = S_ERROR;
      error_d      = 1'b1;
      error_code_d = err_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      hdr_q        <= '0;
      car_q        <= '0;
      cdr_q        <= '0;
      op_q         <= OP_ADD;
      acc_q        <= '0;
      args_q       <= '0;
      first_q      <= 1'b0;
      arg_mode_q   <= 1'b0;
      v_q          <= '0;
      result_q     <= '0;
      error_q      <= 1'b0;
      error_code_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      hdr_q        <= hdr_d;
      car_q        <= car_d;
      cdr_q        <= cdr_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      args_q       <= args_d;
      first_q      <= first_d;
      arg_mode_q   <= arg_mode_d;
      v_q          <= v_d;
      result_q     <= result_d;
      error_q      <= error_d;
      error_code_q <= error_code_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign busy       = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign done       = (state_q == S_DONE);
  assign result     = result_q;
  assign error      = error_q;
  assign error_code = error_code_q;

endmodule

// File: tb/tb_lisp_eval_engine.sv
// Testbench for lisp_eval_engine: heap model with random read latency (1-7
// cycles), expression builders, and a scoreboard queue of expected outcomes.
module tb_lisp_eval_engine;
  import lisp_defs::*;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int STACK_DEPTH = 8;
  localparam int TIMEOUT     = 3000;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] expr_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [14:0]       mem_header;
  logic [15:0]       mem_car;
  logic [15:0]       mem_cdr;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              error;
  logic [3:0]        error_code;

  always #5 clk = ~clk;

  lisp_eval_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .expr_addr(expr_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_header(mem_header), .mem_car(mem_car), .mem_cdr(mem_cdr),
    .busy(busy), .done(done), .result(result), .error(error),
    .error_code(error_code)
  );

  logic [14:0] heap_hdr [512];
  logic [15:0] heap_car [512];
  logic [15:0] heap_cdr [512];
  int heap_top  = 1;
  int checks    = 0;
  int failures  = 0;
  int reads     = 0;
  int done_cnt  = 0;
  int max_depth = 0;

  typedef struct {
    string      tag;
    bit         is_err;
    logic [15:0] val;
    logic [3:0]  code;
  } exp_t;
  exp_t sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int mk(input logic [14:0] h, input logic [15:0] a, input logic [15:0] d);
    int p;
    p = heap_top;
    heap_hdr[p] = h;
    heap_car[p] = a;
    heap_cdr[p] = d;
    heap_top++;
    return p;
  endfunction

  function automatic int mk_num(input logic [15:0] v);
    return mk(TYPE_NUMBER, v, 16'h0);
  endfunction

  function automatic int mk_prim(input logic [15:0] op);
    return mk(TYPE_PRIMITIVE, op, 16'h0);
  endfunction

  function automatic int mk_list(input int items[$]);
    int p;
    p = 0;
    for (int i = items.size() - 1; i >= 0; i--) p = mk(TYPE_CONS, 16'(items[i]), 16'(p));
    return p;
  endfunction

  function automatic int app(input logic [15:0] op, input int a0 = -1, input int a1 = -1,
                             input int a2 = -1);
    int items[$];
    items.push_back(mk_prim(op));
    if (a0 >= 0) items.push_back(a0);
    if (a1 >= 0) items.push_back(a1);
    if (a2 >= 0) items.push_back(a2);
    return mk_list(items);
  endfunction

  // Chain (+ 1 (+ 1 ... (+ 1))) with n nested applications below the root.
  function automatic int nest(input int n);
    int e;
    e = app(PRIMOP_ADD, mk_num(16'd1));
    for (int k = 0; k < n; k++) e = app(PRIMOP_ADD, mk_num(16'd1), e);
    return e;
  endfunction

  // Heap responder: answers each request after 1-7 cycles; gives up if the
  // request is withdrawn (reset).
  initial begin
    mem_ready  = 1'b0;
    mem_header = '0;
    mem_car    = '0;
    mem_cdr    = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_req === 1'b1) begin
        int          lat;
        logic [15:0] a;
        bit          live;
        lat  = int'($urandom_range(1, 7));
        a    = mem_addr;
        live = 1'b1;
        reads++;
        for (int i = 1; i < lat; i++) begin
          @(negedge clk);
          if (mem_req !== 1'b1) begin
            live = 1'b0;
            break;
          end
        end
        if (live) begin
          mem_header = heap_hdr[a[8:0]];
          mem_car    = heap_car[a[8:0]];
          mem_cdr    = heap_cdr[a[8:0]];
          mem_ready  = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (int'(dut.u_stack.count_q) > max_depth) max_depth = int'(dut.u_stack.count_q);
    end
  end

  task automatic run_expr(input string tag, input int root, input bit is_err,
                          input logic [15:0] val, input logic [3:0] code);
    exp_t e;
    int   cyc;
    sb_q.push_back('{tag, is_err, val, code});
    @(negedge clk);
    expr_addr = 16'(root);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (done !== 1'b1 && error !== 1'b1 && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    e = sb_q.pop_front();
    if (cyc >= TIMEOUT) begin
      check_val({e.tag, "_timeout"}, 32'(cyc), 32'(0));
    end else if (e.is_err) begin
      check_val({e.tag, "_error"}, 32'(error), 32'(1));
      check_val({e.tag, "_code"}, 32'(error_code), 32'(e.code));
    end else begin
      check_val({e.tag, "_error"}, 32'(error), 32'(0));
      check_val({e.tag, "_result"}, 32'(result), 32'(e.val));
    end
    $display("txn %s: root=%0d done=%0b error=%0b code=%0d result=0x%04h cycles=%0d",
             e.tag, root, done, error, error_code, result, cyc);
  endtask

  initial begin
    int r_num, r_add, r_sub, r_wrap, r_mul0, r_add0, r_n8, r_n9, r_mix;
    int r_bad_op, r_sub0, r_prim, r_dot, r_badcode, r_rst, r_11;
    int it[$];
    int base, cyc;

    for (int i = 0; i < 512; i++) begin
      heap_hdr[i] = '0;
      heap_car[i] = '0;
      heap_cdr[i] = '0;
    end

    r_num  = mk_num(16'h002A);
    r_add  = app(PRIMOP_ADD, mk_num(16'd3), mk_num(16'd4), mk_num(16'd5));
    r_sub  = app(PRIMOP_SUB, mk_num(16'd10),
                 app(PRIMOP_MUL, mk_num(16'd2), mk_num(16'd3)), mk_num(16'd1));
    r_wrap = app(PRIMOP_ADD, mk_num(16'hFFFF), mk_num(16'd2));
    r_mul0 = app(PRIMOP_MUL);
    r_add0 = app(PRIMOP_ADD);
    r_n8   = nest(STACK_DEPTH);
    r_n9   = nest(STACK_DEPTH + 1);
    r_mix  = app(PRIMOP_MUL, mk_num(16'd3),
                 app(PRIMOP_ADD, mk_num(16'd1), mk_num(16'd2)),
                 app(PRIMOP_SUB, mk_num(16'd7)));
    it.push_back(mk_num(16'd5));
    it.push_back(mk_num(16'd1));
    r_bad_op  = mk_list(it);
    r_sub0    = app(PRIMOP_SUB);
    r_prim    = mk_prim(PRIMOP_ADD);
    r_dot     = mk(TYPE_CONS, 16'(mk_prim(PRIMOP_ADD)), 16'(mk_num(16'd5)));
    r_badcode = app(16'd3, mk_num(16'd1));
    r_rst     = app(PRIMOP_ADD, mk_num(16'd7), mk_num(16'd8));
    r_11      = app(PRIMOP_ADD, mk_num(16'd1), mk_num(16'd1));

    rst       = 1'b1;
    start     = 1'b0;
    expr_addr = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'(0));
    check_val("rst_done", 32'(done), 32'(0));
    check_val("rst_error", 32'(error), 32'(0));
    check_val("rst_mem_req", 32'(mem_req), 32'(0));
    check_val("rst_result", 32'(result), 32'(0));
    check_val("rst_error_code", 32'(error_code), 32'(0));
    $display("txn reset: busy=%0b done=%0b error=%0b result=0x%04h", busy, done, error, result);
    rst = 1'b0;

    base = reads;
    run_expr("number", r_num, 1'b0, 16'h002A, 4'd0);
    check_val("number_reads", 32'(reads - base), 32'(1));

    base = done_cnt;
    run_expr("add3", r_add, 1'b0, 16'h000C, 4'd0);
    repeat (4) @(negedge clk);
    check_val("add3_done_pulses", 32'(done_cnt - base), 32'(1));
    check_val("add3_busy_after", 32'(busy), 32'(0));

    max_depth = 0;
    run_expr("sub_nested", r_sub, 1'b0, 16'h0003, 4'd0);
    check_val("sub_nested_max_depth", 32'(max_depth), 32'(1));

    run_expr("add_wrap", r_wrap, 1'b0, 16'h0001, 4'd0);
    run_expr("mul_empty", r_mul0, 1'b0, 16'h0001, 4'd0);
    run_expr("add_empty", r_add0, 1'b0, 16'h0000, 4'd0);

    max_depth = 0;
    run_expr("nest_full", r_n8, 1'b0, 16'(STACK_DEPTH + 1), 4'd0);
    check_val("nest_full_max_depth", 32'(max_depth), 32'(STACK_DEPTH));
    run_expr("nest_overflow", r_n9, 1'b1, 16'h0, ERR_OVERFLOW);

    run_expr("mixed", r_mix, 1'b0, 16'd63, 4'd0);
    run_expr("number_op", r_bad_op, 1'b1, 16'h0, ERR_APPLY);
    run_expr("sub_empty", r_sub0, 1'b1, 16'h0, ERR_ARITY);
    run_expr("prim_root", r_prim, 1'b1, 16'h0, ERR_EVAL_TYPE);
    run_expr("dotted_args", r_dot, 1'b1, 16'h0, ERR_EVAL_TYPE);
    run_expr("unknown_op", r_badcode, 1'b1, 16'h0, ERR_APPLY);
    check_val("result_held", 32'(result), 32'(63));

    // Reset while a read is outstanding.
    @(negedge clk);
    expr_addr = 16'(r_rst);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (mem_req !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_val("rst_mid_req_seen", 32'(mem_req), 32'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_mid_mem_req", 32'(mem_req), 32'(0));
    check_val("rst_mid_busy", 32'(busy), 32'(0));
    check_val("rst_mid_result", 32'(result), 32'(0));
    $display("txn reset_mid: mem_req=%0b busy=%0b result=0x%04h", mem_req, busy, result);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    run_expr("add_after_rst", r_11, 1'b0, 16'h0002, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
